// File: rtl/score_counter_ctrl.sv
// Debounced key-driven up/down counter saturating at 0..MAX_COUNT, feeding a two-digit display decoder.
// Optional auto-increment timer and its auto_en port are enabled by defining AUTO_INC_EN.
//
//   state | meaning
//   ZERO  | count == 0
//   MID   | 0 < count < MAX_COUNT
//   FULL  | count == MAX_COUNT
module score_counter_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int MAX_COUNT       = 10,
    parameter int TICK_CYCLES     = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_inc_n,
    input  logic       btn_dec_n,
    input  logic       btn_clr_n,
`ifdef AUTO_INC_EN
    input  logic       auto_en,
`endif
    output logic [3:0] count,
    output logic       at_zero,
    output logic       at_max,
    output logic       changed
);

    typedef enum logic [1:0] {
        ST_ZERO = 2'd0,
        ST_MID  = 2'd1,
        ST_FULL = 2'd2
    } state_t;

    localparam int             DW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0]  DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0]     MAX_V   = 4'(MAX_COUNT);

    // key index: 0 = inc, 1 = dec, 2 = clr
    logic [2:0]    raw_n;
    logic [2:0]    s1_q;
    logic [2:0]    s2_q;
    logic [2:0]    stable_q;
    logic [2:0]    stable_dly_q;
    logic [2:0]    press_q;
    logic [DW-1:0] db_cnt_q [3];

    assign raw_n = {btn_clr_n, btn_dec_n, btn_inc_n};

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q         <= '1;
            s2_q         <= '1;
            stable_q     <= '1;
            stable_dly_q <= '1;
            press_q      <= '0;
            for (int k = 0; k < 3; k++) begin
                db_cnt_q[k] <= '0;
            end
        end else begin
            s1_q         <= raw_n;
            s2_q         <= s1_q;
            stable_dly_q <= stable_q;
            // registered falling edge of the debounced level; releases produce nothing
            press_q      <= stable_dly_q & ~stable_q;
            for (int k = 0; k < 3; k++) begin
                if (s2_q[k] == stable_q[k]) begin
                    db_cnt_q[k] <= '0;
                end else if (db_cnt_q[k] == DB_LAST) begin
                    stable_q[k] <= s2_q[k];
                    db_cnt_q[k] <= '0;
                end else begin
                    db_cnt_q[k] <= db_cnt_q[k] + 1'b1;
                end
            end
        end
    end

    logic       inc_ev;
    logic       dec_ev;
    logic       clr_ev;
    logic       tick;
    state_t     state_q;
    state_t     state_d;
    logic [3:0] count_q;
    logic [3:0] count_d;
    logic       at_zero_q;
    logic       at_max_q;
    logic       changed_q;
    logic       up;
    logic       dn;

    assign inc_ev = press_q[0];
    assign dec_ev = press_q[1];
    assign clr_ev = press_q[2];

`ifdef AUTO_INC_EN
    localparam int            TW          = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TW-1:0] TICK_RELOAD = TW'(TICK_CYCLES - 1);

    logic [TW-1:0] tick_q;
    logic [TW-1:0] tick_d;
    logic          manual_ev;

    assign manual_ev = |press_q;

    // a manual event in the same cycle wins; the coincident tick is simply dropped
    always_comb begin
        tick   = 1'b0;
        tick_d = tick_q;
        if (!auto_en || manual_ev || state_q == ST_FULL) begin
            tick_d = TICK_RELOAD;
        end else if (tick_q == '0) begin
            tick   = 1'b1;
            tick_d = TICK_RELOAD;
        end else begin
            tick_d = tick_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q <= TICK_RELOAD;
        end else begin
            tick_q <= tick_d;
        end
    end
`else
    assign tick = 1'b0;
`endif

    assign up = inc_ev | tick;
    assign dn = dec_ev;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (clr_ev) begin
            state_d = ST_ZERO;
            count_d = 4'd0;
        end else if (up && !dn) begin
            case (state_q)
                ST_ZERO: begin
                    count_d = 4'd1;
                    state_d = (MAX_V == 4'd1) ? ST_FULL : ST_MID;
                end
                ST_MID: begin
                    count_d = count_q + 4'd1;
                    state_d = (count_q == MAX_V - 4'd1) ? ST_FULL : ST_MID;
                end
                ST_FULL: begin
                    count_d = count_q;
                end
                default: begin
                    state_d = ST_ZERO;
                    count_d = 4'd0;
                end
            endcase
        end else if (dn && !up) begin
            case (state_q)
                ST_ZERO: begin
                    count_d = count_q;
                end
                ST_MID: begin
                    count_d = count_q - 4'd1;
                    state_d = (count_q == 4'd1) ? ST_ZERO : ST_MID;
                end
                ST_FULL: begin
                    count_d = count_q - 4'd1;
                    state_d = (MAX_V == 4'd1) ? ST_ZERO : ST_MID;
                end
                default: begin
                    state_d = ST_ZERO;
                    count_d = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_ZERO;
            count_q   <= 4'd0;
            at_zero_q <= 1'b1;
            at_max_q  <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            at_zero_q <= (count_d == 4'd0);
            at_max_q  <= (count_d == MAX_V);
            changed_q <= (count_d != count_q);
        end
    end

    assign count   = count_q;
    assign at_zero = at_zero_q;
    assign at_max  = at_max_q;
    assign changed = changed_q;

endmodule

// File: tb/tb_score_counter_ctrl.sv
// Randomized self-checking bench for score_counter_ctrl against a key-press level reference model.
// Auto-increment checks are compiled in when AUTO_INC_EN is defined.
module tb_score_counter_ctrl;

    localparam int D    = 4;
    localparam int MAXC = 10;
    localparam int T    = 8;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       inc_n = 1'b1;
    logic       dec_n = 1'b1;
    logic       clr_n = 1'b1;
`ifdef AUTO_INC_EN
    logic       auto_en = 1'b0;
`endif
    logic [3:0] count;
    logic       at_zero;
    logic       at_max;
    logic       changed;

    int n_cmp   = 0;
    int n_err   = 0;
    int chg_cnt = 0;
    int model   = 0;

    score_counter_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .MAX_COUNT      (MAXC),
        .TICK_CYCLES    (T)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_inc_n(inc_n),
        .btn_dec_n(dec_n),
        .btn_clr_n(clr_n),
`ifdef AUTO_INC_EN
        .auto_en  (auto_en),
`endif
        .count    (count),
        .at_zero  (at_zero),
        .at_max   (at_max),
        .changed  (changed)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (changed === 1'b1) chg_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference rule for one accepted set of simultaneous key presses.
    function automatic int apply_keys(input int c, input bit i, input bit d, input bit cl);
        if (cl) return 0;
        if (i && d) return c;
        if (i) return (c < MAXC) ? c + 1 : c;
        if (d) return (c > 0) ? c - 1 : 0;
        return c;
    endfunction

    task automatic press(input bit i, input bit d, input bit c, input int len);
        @(negedge clk);
        inc_n = ~i;
        dec_n = ~d;
        clr_n = ~c;
        repeat (len) @(negedge clk);
        inc_n = 1'b1;
        dec_n = 1'b1;
        clr_n = 1'b1;
        repeat (D + 8) @(negedge clk);
    endtask

    // A key level held for at least D sampled edges is a press; shorter is a glitch.
    task automatic op(input string tag, input bit i, input bit d, input bit c, input int len);
        int old;
        int c0;
        old = model;
        c0  = chg_cnt;
        press(i, d, c, len);
        if (len >= D) model = apply_keys(model, i, d, c);
        chk({tag, ".count"},   32'(count),       32'(model));
        chk({tag, ".at_zero"}, 32'(at_zero),     32'(model == 0));
        chk({tag, ".at_max"},  32'(at_max),      32'(model == MAXC));
        chk({tag, ".changed"}, 32'(chg_cnt - c0), 32'(model != old));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst   = 1'b0;
        model = 0;
    endtask

    initial begin
        int         first;
        int         pulses;
        int         c0;
        logic [2:0] mask;
        int         len;

        repeat (2) @(negedge clk);
        chk("rst.count",   32'(count),   32'd0);
        chk("rst.at_zero", 32'(at_zero), 32'd1);
        chk("rst.at_max",  32'(at_max),  32'd0);
        chk("rst.changed", 32'(changed), 32'd0);
        rst = 1'b0;

        // clean press held 10 edges: count moves at edge D+3 with a single pulse
        @(negedge clk);
        inc_n  = 1'b0;
        first  = -1;
        pulses = 0;
        for (int e = 0; e < 12; e++) begin
            @(posedge clk);
            #1;
            if (first < 0 && count == 4'd1) first = e;
            if (changed === 1'b1) pulses++;
            if (e == 9) inc_n = 1'b1;
        end
        chk("lat.edge",  32'(first),  32'(D + 3));
        chk("lat.pulse", 32'(pulses), 32'd1);
        model = 1;
        repeat (D + 8) @(negedge clk);

        // bounce: low 3, high 1, low 2
        do_reset();
        c0 = chg_cnt;
        @(negedge clk);
        inc_n = 1'b0;
        repeat (3) @(negedge clk);
        inc_n = 1'b1;
        @(negedge clk);
        inc_n = 1'b0;
        repeat (2) @(negedge clk);
        inc_n = 1'b1;
        repeat (D + 8) @(negedge clk);
        chk("bounce.count",   32'(count),         32'd0);
        chk("bounce.changed", 32'(chg_cnt - c0),  32'd0);

        for (int n = 0; n < 12; n++) op("inc", 1'b1, 1'b0, 1'b0, D + 2);
        chk("inc12.count",  32'(count),  32'(MAXC));
        chk("inc12.at_max", 32'(at_max), 32'd1);

        do_reset();
        op("dec0", 1'b0, 1'b1, 1'b0, D + 2);
        for (int n = 0; n < 5; n++) op("to5", 1'b1, 1'b0, 1'b0, D + 2);
        op("incdec", 1'b1, 1'b1, 1'b0, D + 2);
        chk("incdec.const", 32'(count), 32'd5);
        op("clrinc", 1'b1, 1'b0, 1'b1, D + 2);
        chk("clrinc.const", 32'(count), 32'd0);
        op("clr0", 1'b0, 1'b0, 1'b1, D + 2);
        op("lenD",   1'b1, 1'b0, 1'b0, D);
        op("lenDm1", 1'b1, 1'b0, 1'b0, D - 1);

        // reset mid-debounce with the key released during reset
        op("pre", 1'b1, 1'b0, 1'b0, D + 2);
        @(negedge clk);
        inc_n = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        inc_n = 1'b1;
        rst   = 1'b0;
        model = 0;
        c0    = chg_cnt;
        repeat (2 * D + 8) @(negedge clk);
        chk("rstmid.count",   32'(count),        32'd0);
        chk("rstmid.changed", 32'(chg_cnt - c0), 32'd0);

        // key held across reset: one press D+3 edges after release of rst
        inc_n = 1'b0;
        rst   = 1'b1;
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        c0     = chg_cnt;
        first  = -1;
        for (int e = 0; e < D + 8; e++) begin
            @(posedge clk);
            #1;
            if (first < 0 && count == 4'd1) first = e;
        end
        inc_n = 1'b1;
        repeat (D + 8) @(negedge clk);
        model = 1;
        chk("rsthold.edge",    32'(first),        32'(D + 3));
        chk("rsthold.count",   32'(count),        32'd1);
        chk("rsthold.changed", 32'(chg_cnt - c0), 32'd1);

        for (int n = 0; n < 40; n++) begin
            mask = 3'($urandom_range(1, 7));
            len  = $urandom_range(1, 2 * D + 1);
            op("rnd", mask[0], mask[1], mask[2], len);
        end

`ifdef AUTO_INC_EN
        op("auto.clr", 1'b0, 1'b0, 1'b1, D + 2);
        @(negedge clk);
        auto_en = 1'b1;
        first   = -1;
        pulses  = 0;
        for (int cyc = 0; cyc < T * (MAXC + 3); cyc++) begin
            @(posedge clk);
            #1;
            if (changed === 1'b1) begin
                if (first >= 0) chk("auto.period", 32'(cyc - first), 32'(T));
                first = cyc;
                pulses++;
            end
        end
        auto_en = 1'b0;
        model   = MAXC;
        chk("auto.pulses", 32'(pulses), 32'(MAXC));
        chk("auto.count",  32'(count),  32'(MAXC));
        chk("auto.at_max", 32'(at_max), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
